// File: rtl/data_memory_io_if.sv
// CPU load/store bus into data_memory_io: strobes, byte enables, address,
// write data and the registered read response.
interface data_memory_io_if #(
    parameter int ADDR_BIT_WIDTH = 32,
    parameter int DATA_BIT_WIDTH = 32
);
    logic                        wrtEn;
    logic                        rdEn;
    logic [DATA_BIT_WIDTH/8-1:0] be;
    logic [ADDR_BIT_WIDTH-1:0]   addr;
    logic [DATA_BIT_WIDTH-1:0]   dIn;
    logic [DATA_BIT_WIDTH-1:0]   dOut;
    logic                        dValid;

    modport master (output wrtEn, rdEn, be, addr, dIn, input dOut, dValid);
    modport slave  (input wrtEn, rdEn, be, addr, dIn, output dOut, dValid);
endinterface

// File: rtl/data_memory_io.sv
// Data memory with byte-enable RAM and memory-mapped board I/O (keys, switches,
// LEDs, hex, sticky key capture + irq). Define DMEM_TIMER_EN for the timer at I/O offset 6.
module data_memory_io #(
    parameter string MEM_INIT_FILE       = "",
    parameter int    ADDR_BIT_WIDTH      = 32,
    parameter int    DATA_BIT_WIDTH      = 32,
    parameter int    TRUE_ADDR_BIT_WIDTH = 11,
    parameter int    N_WORDS             = 1 << TRUE_ADDR_BIT_WIDTH,
    parameter int    IO_SEL_BIT          = 29,
    parameter int    N_SW                = 10,
    parameter int    N_KEY               = 4,
    parameter int    N_LEDR              = 10,
    parameter int    N_LEDG              = 8,
    parameter int    HEX_WIDTH           = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    data_memory_io_if.slave      bus,
    input  logic [N_SW-1:0]      sw,
    input  logic [N_KEY-1:0]     key,
    output logic [N_LEDR-1:0]    ledr,
    output logic [N_LEDG-1:0]    ledg,
    output logic [HEX_WIDTH-1:0] hex,
    output logic                 keyIrq
);
    localparam int NB = DATA_BIT_WIDTH / 8;

    (* ram_init_file = MEM_INIT_FILE *)
    logic [DATA_BIT_WIDTH-1:0] mem_r [N_WORDS];

    logic [TRUE_ADDR_BIT_WIDTH-1:0] word_idx_s;
    logic                           io_sel_s;
    logic [2:0]                     io_off_s;
    logic                           ram_wr_s;
    logic                           io_wr_s;
    logic [DATA_BIT_WIDTH-1:0]      io_rdata_s;
    logic [N_KEY-1:0]               press_s;
    logic [N_KEY-1:0]               keycap_clr_s;
    logic [N_KEY-1:0]               keycap_next_s;
    logic                           unused_s;

    logic [N_SW-1:0]           sw_s1_r, sw_s2_r;
    logic [N_KEY-1:0]          key_s1_r, key_s2_r, key_prev_r;
    logic [N_KEY-1:0]          keycap_r;
    logic                      keyirq_r;
    logic [N_LEDR-1:0]         ledr_r;
    logic [N_LEDG-1:0]         ledg_r;
    logic [HEX_WIDTH-1:0]      hex_r;
    logic [DATA_BIT_WIDTH-1:0] dout_r;
    logic                      dvalid_r;
`ifdef DMEM_TIMER_EN
    logic [31:0]               timer_r;
`endif

    assign word_idx_s = bus.addr[TRUE_ADDR_BIT_WIDTH+1:2];
    assign io_sel_s   = bus.addr[IO_SEL_BIT];
    assign io_off_s   = bus.addr[4:2];
    assign ram_wr_s   = bus.wrtEn & ~io_sel_s;
    assign io_wr_s    = bus.wrtEn & io_sel_s;
    assign unused_s   = &{1'b0, bus.addr, bus.dIn};

    // RAM byte-lane writes; contents deliberately survive reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (ram_wr_s && bus.be[i]) begin
                mem_r[word_idx_s][8*i +: 8] <= bus.dIn[8*i +: 8];
            end
        end
    end

    // Two-flop synchronisers; key_prev_r is the third stage used for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            sw_s1_r    <= '0;
            sw_s2_r    <= '0;
            key_s1_r   <= '0;
            key_s2_r   <= '0;
            key_prev_r <= '0;
        end else begin
            sw_s1_r    <= sw;
            sw_s2_r    <= sw_s1_r;
            key_s1_r   <= ~key;
            key_s2_r   <= key_s1_r;
            key_prev_r <= key_s2_r;
        end
    end

    // New presses are ORed in after the clear, so a coincident press keeps its bit
    always_comb begin
        press_s       = key_s2_r & ~key_prev_r;
        keycap_clr_s  = (io_wr_s && (io_off_s == 3'd5)) ? bus.dIn[N_KEY-1:0] : '0;
        keycap_next_s = (keycap_r & ~keycap_clr_s) | press_s;
    end

    // I/O read mux, zero-extended to the bus width
    always_comb begin
        io_rdata_s = '0;
        case (io_off_s)
            3'd0:    io_rdata_s = DATA_BIT_WIDTH'(key_s2_r);
            3'd1:    io_rdata_s = DATA_BIT_WIDTH'(sw_s2_r);
            3'd2:    io_rdata_s = DATA_BIT_WIDTH'(ledr_r);
            3'd3:    io_rdata_s = DATA_BIT_WIDTH'(ledg_r);
            3'd4:    io_rdata_s = DATA_BIT_WIDTH'(hex_r);
            3'd5:    io_rdata_s = DATA_BIT_WIDTH'(keycap_r);
`ifdef DMEM_TIMER_EN
            3'd6:    io_rdata_s = DATA_BIT_WIDTH'(timer_r);
`endif
            default: io_rdata_s = '0;
        endcase
    end

    // Read response, output registers and key capture
    always_ff @(posedge clk) begin
        if (reset) begin
            dout_r   <= '0;
            dvalid_r <= 1'b0;
            ledr_r   <= '0;
            ledg_r   <= '0;
            hex_r    <= '0;
            keycap_r <= '0;
            keyirq_r <= 1'b0;
        end else begin
            dvalid_r <= bus.rdEn;
            if (bus.rdEn) begin
                dout_r <= io_sel_s ? io_rdata_s : mem_r[word_idx_s];
            end
            keycap_r <= keycap_next_s;
            keyirq_r <= |keycap_next_s;
            if (io_wr_s) begin
                case (io_off_s)
                    3'd2:    ledr_r <= bus.dIn[N_LEDR-1:0];
                    3'd3:    ledg_r <= bus.dIn[N_LEDG-1:0];
                    3'd4:    hex_r  <= bus.dIn[HEX_WIDTH-1:0];
                    default: ledr_r <= ledr_r;
                endcase
            end
        end
    end

`ifdef DMEM_TIMER_EN
    // Free-running counter; a bus write overrides that cycle's increment
    always_ff @(posedge clk) begin
        if (reset) begin
            timer_r <= 32'd0;
        end else if (io_wr_s && (io_off_s == 3'd6)) begin
            timer_r <= 32'(bus.dIn);
        end else begin
            timer_r <= timer_r + 32'd1;
        end
    end
`endif

    assign bus.dOut   = dout_r;
    assign bus.dValid = dvalid_r;
    assign ledr       = ledr_r;
    assign ledg       = ledg_r;
    assign hex        = hex_r;
    assign keyIrq     = keyirq_r;
endmodule

// File: tb/tb_data_memory_io.sv
// Scoreboard bench for data_memory_io: a behavioural model predicts read data,
// pin values and key capture; a negedge monitor checks every dValid response.
module tb_data_memory_io;
    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] sw;
    logic [3:0] key;
    logic [9:0] ledr;
    logic [7:0] ledg;
    logic [15:0] hex;
    logic       keyIrq;

    data_memory_io_if #(.ADDR_BIT_WIDTH(32), .DATA_BIT_WIDTH(32)) bus ();

    data_memory_io dut (
        .clk(clk), .reset(reset), .bus(bus), .sw(sw), .key(key),
        .ledr(ledr), .ledg(ledg), .hex(hex), .keyIrq(keyIrq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // reference model state
    logic [31:0] ram_m [2048];
    logic [9:0]  ledr_m;
    logic [7:0]  ledg_m;
    logic [15:0] hex_m;
    logic [3:0]  keycap_m;
    logic [31:0] timer_val;
    int          timer_cyc;
    logic [9:0]  sw_hist  [8192];
    logic [3:0]  key_hist [8192];
    int          rst_last = 0;

    logic [31:0] exp_q [$];
    int          cyc_q [$];

    // A pin value driven in cycle j is visible to a read issued two cycles later
    function automatic logic [9:0] sw_sync(input int j);
        if (j >= rst_last + 3) return sw_hist[j-2];
        else return 10'd0;
    endfunction

    function automatic logic [3:0] key_sync(input int j);
        if (j >= rst_last + 3) return key_hist[j-2];
        else return 4'd0;
    endfunction

    function automatic logic [31:0] exp_read(input logic [31:0] a, input int j);
        if (!a[29]) return ram_m[a[12:2]];
        case (a[4:2])
            3'd0: return {28'd0, key_sync(j)};
            3'd1: return {22'd0, sw_sync(j)};
            3'd2: return {22'd0, ledr_m};
            3'd3: return {24'd0, ledg_m};
            3'd4: return {16'd0, hex_m};
            3'd5: return {28'd0, keycap_m};
`ifdef DMEM_TIMER_EN
            3'd6: return timer_val + 32'(j - timer_cyc - 1);
`endif
            default: return 32'd0;
        endcase
    endfunction

    task automatic step(input bit w, input bit r, input logic [3:0] be,
                        input logic [31:0] a, input logic [31:0] d, input bit rst);
        int j;
        logic [3:0] press;
        logic [3:0] clr;
        j = cyc;
        sw_hist[j]  = sw;
        key_hist[j] = ~key;
        if (rst) begin
            rst_last  = j;
            ledr_m    = 10'd0;
            ledg_m    = 8'd0;
            hex_m     = 16'd0;
            keycap_m  = 4'd0;
            timer_val = 32'd0;
            timer_cyc = j;
        end else begin
            if (r) begin
                exp_q.push_back(exp_read(a, j));
                cyc_q.push_back(j);
            end
            press = key_sync(j) & ~key_sync(j-1);
            clr = (w && a[29] && a[4:2] == 3'd5) ? d[3:0] : 4'd0;
            keycap_m = (keycap_m & ~clr) | press;
            if (w && !a[29]) begin
                for (int i = 0; i < 4; i++)
                    if (be[i]) ram_m[a[12:2]][8*i +: 8] = d[8*i +: 8];
            end else if (w) begin
                case (a[4:2])
                    3'd2: ledr_m = d[9:0];
                    3'd3: ledg_m = d[7:0];
                    3'd4: hex_m  = d[15:0];
                    3'd6: begin timer_val = d; timer_cyc = j; end
                    default: ;
                endcase
            end
        end
        bus.wrtEn = w;
        bus.rdEn  = r;
        bus.be    = be;
        bus.addr  = a;
        bus.dIn   = d;
        reset     = rst;
        @(posedge clk);
        #1;
        chk("ledr_pin", {22'd0, ledr}, {22'd0, ledr_m});
        chk("ledg_pin", {24'd0, ledg}, {24'd0, ledg_m});
        chk("hex_pin",  {16'd0, hex},  {16'd0, hex_m});
        chk("key_irq",  {31'd0, keyIrq}, {31'd0, |keycap_m});
        if (rst) begin
            chk("reset_dout",   bus.dOut, 32'd0);
            chk("reset_dvalid", {31'd0, bus.dValid}, 32'd0);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        step(1'b1, 1'b0, be, a, d, 1'b0);
    endtask

    task automatic rd(input logic [31:0] a);
        step(1'b0, 1'b1, 4'h0, a, 32'd0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 4'h0, 32'd0, 32'd0, 1'b0);
    endtask

    // monitor: every dValid must match the oldest outstanding read, one cycle after issue
    always @(negedge clk) begin : monitor
        logic [31:0] e;
        int c;
        if (bus.dValid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_dvalid: got dValid=1 with dOut=%h, expected no response", bus.dOut);
            end else begin
                e = exp_q.pop_front();
                c = cyc_q.pop_front();
                chk("read_data", bus.dOut, e);
                chk("read_latency", 32'(cyc), 32'(c + 1));
            end
        end else if (cyc_q.size() > 0 && cyc_q[0] + 1 <= cyc) begin
            checks++;
            errors++;
            $display("FAIL missing_dvalid: got dValid=0, expected response %h", exp_q[0]);
            void'(exp_q.pop_front());
            void'(cyc_q.pop_front());
        end
    end

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        int op;
        sw = 10'd0;
        key = 4'hF;
        bus.wrtEn = 1'b0;
        bus.rdEn = 1'b0;
        bus.be = 4'h0;
        bus.addr = 32'd0;
        bus.dIn = 32'd0;
        reset = 1'b1;
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 4'h0, 32'd0, 32'd0, 1'b1);

        // byte-enable merge
        wr(32'h0000_0040, 32'hDEAD_BEEF, 4'hF);
        wr(32'h0000_0040, 32'h0000_AA00, 4'b0010);
        rd(32'h0000_0040);
        idle(2);

        // read-first on a same-cycle write, then aliasing
        wr(32'h0000_0000, 32'h0, 4'hF);
        step(1'b1, 1'b1, 4'hF, 32'h0000_0000, 32'h1, 1'b0);
        rd(32'h0000_0000);
        rd(32'h0000_2000);
        idle(1);

        // LED / hex registers
        wr(32'h2000_0008, 32'h0000_03FF, 4'h0);
        wr(32'h2000_000C, 32'hFFFF_FFA5, 4'h0);
        wr(32'h2000_0010, 32'h0000_1234, 4'h0);
        rd(32'h2000_0008);
        rd(32'h2000_000C);
        rd(32'h2000_0010);
        step(1'b1, 1'b1, 4'hF, 32'h2000_0008, 32'h0000_0055, 1'b0);
        rd(32'h2000_0008);

        // key press, sticky capture, clear, clear coincident with a new press
        key = 4'b1011;
        idle(5);
        rd(32'h2000_0000);
        rd(32'h2000_0014);
        key = 4'hF;
        idle(4);
        wr(32'h2000_0014, 32'h4, 4'h0);
        rd(32'h2000_0014);
        key = 4'b1011;
        idle(2);
        wr(32'h2000_0014, 32'h4, 4'h0);
        rd(32'h2000_0014);
        idle(2);
        key = 4'hF;
        idle(3);
        wr(32'h2000_0014, 32'hF, 4'h0);

        // switch synchroniser latency and reserved offset
        sw = 10'h155;
        rd(32'h2000_0004);
        rd(32'h2000_0004);
        rd(32'h2000_0004);
        rd(32'h2000_001C);
        wr(32'h2000_001C, 32'hFFFF_FFFF, 4'hF);
        rd(32'h2000_001C);

        // reset during reads and with LEDs lit
        wr(32'h2000_0008, 32'h2AA, 4'h0);
        step(1'b0, 1'b1, 4'h0, 32'h0000_0040, 32'd0, 1'b1);
        rd(32'h0000_0040);
        step(1'b0, 1'b0, 4'h0, 32'd0, 32'd0, 1'b1);
        idle(1);
        rd(32'h0000_0040);

        // timer (reads 0 when the feature is absent)
        wr(32'h2000_0018, 32'd100, 4'h0);
        idle(1);
        rd(32'h2000_0018);
        idle(1);

        // randomized traffic over 16 words (with aliases) and the I/O region
        for (int i = 0; i < 16; i++) wr(32'(i) << 2, $urandom, 4'hF);
        for (int n = 0; n < 500; n++) begin
            op = $urandom_range(0, 6);
            a = (($urandom & 32'hDFFF_E000) | (32'($urandom_range(0, 15)) << 2)
                 | 32'($urandom_range(0, 3)));
            d = $urandom;
            case (op)
                0: wr(a, d, 4'($urandom_range(0, 15)));
                1: rd(a);
                2: step(1'b1, 1'b1, 4'($urandom_range(0, 15)), a, d, 1'b0);
                3: wr(32'h2000_0000 | (32'($urandom_range(0, 7)) << 2), d, 4'h0);
                4: rd(32'h2000_0000 | (32'($urandom_range(0, 7)) << 2));
                5: begin sw = 10'($urandom); idle(1); end
                default: begin key = 4'($urandom); idle(1); end
            endcase
        end
        idle(3);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL outstanding_reads: got %0d pending, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
